// File: rtl/mux_pkg.sv
// Shared definitions for the stream mux/arbiter family: arbitration modes and a
// constant-foldable log2 helper used to size index fields.
package mux_pkg;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned res;
    int unsigned v;
    res = 0;
    v   = (value > 0) ? value - 1 : 0;
    while (v > 0) begin
      res = res + 1;
      v   = v >> 1;
    end
    return res;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// N-way arbiter: lowest-index fixed priority or round-robin starting after ptr.
// Purely combinational; the caller owns the pointer register.
module rr_arbiter
  import mux_pkg::*;
#(
  parameter  int unsigned N    = 3,
  localparam int unsigned SELW = clog2(N)
) (
  input  logic [N-1:0]    req,
  input  logic [SELW-1:0] ptr,
  input  logic            mode,
  output logic [N-1:0]    gnt,
  output logic [SELW-1:0] gnt_idx,
  output logic            any
);

  logic              found;
  logic [SELW-1:0]   idx;

  // Walk candidates in priority order; the first requester wins.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    idx     = '0;
    for (int unsigned k = 0; k < N; k++) begin
      if (mode == MODE_RR) begin
        idx = SELW'((32'(ptr) + 32'd1 + k) % N);
      end else begin
        idx = SELW'(k);
      end
      if (!found && req[idx]) begin
        found        = 1'b1;
        gnt[idx]     = 1'b1;
        gnt_idx      = idx;
      end
    end
  end

  assign any = |req;

endmodule

// File: rtl/stream_mux_arb.sv
// N-to-1 valid/ready stream selector with a registered output stage.
// Arbitrates only when the output register can load; supports a forced channel.
module stream_mux_arb
  import mux_pkg::*;
#(
  parameter  int unsigned WIDTH = 32,
  parameter  int unsigned N     = 3,
  localparam int unsigned SELW  = clog2(N)
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic [N*WIDTH-1:0]   in_data,
  input  logic [N-1:0]         in_valid,
  output logic [N-1:0]         in_ready,
  input  logic                 mode,
  input  logic                 force_en,
  input  logic [SELW-1:0]      force_sel,
  output logic [WIDTH-1:0]     out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [SELW-1:0]      out_sel
);

  logic              loadEn;
  logic [N-1:0]      elig;
  logic [N-1:0]      gnt;
  logic [SELW-1:0]   gntIdx;
  logic              anyGnt;
  logic [SELW-1:0]   rrPtr;
  logic [WIDTH-1:0]  selData;

  assign loadEn = !out_valid || out_ready;

  // An out-of-range forced index leaves nothing eligible.
  always_comb begin
    elig = in_valid;
    if (force_en) begin
      elig = '0;
      if (32'(force_sel) < N) begin
        elig[force_sel] = in_valid[force_sel];
      end
    end
  end

  rr_arbiter #(.N(N)) uArb (
    .req     (elig),
    .ptr     (rrPtr),
    .mode    (mode),
    .gnt     (gnt),
    .gnt_idx (gntIdx),
    .any     (anyGnt)
  );

  assign in_ready = (loadEn && !Reset) ? gnt : '0;

  always_comb begin
    selData = '0;
    for (int i = 0; i < int'(N); i++) begin
      if (gnt[i]) begin
        selData = in_data[i*WIDTH +: WIDTH];
      end
    end
  end

  // Output register and round-robin history; the pointer moves only on a transfer.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= '0;
      rrPtr     <= SELW'(N - 1);
    end else if (loadEn) begin
      out_valid <= anyGnt;
      if (anyGnt) begin
        out_data <= selData;
        out_sel  <= gntIdx;
        rrPtr    <= gntIdx;
      end
    end
  end

endmodule
